// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port: fetch requester, data requester and memory macro.
// The arbiter uses the slave view; the surrounding pipeline and memory use the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          stall;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_valid, if_rdata,
        output dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_valid, if_rdata,
        input  dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data memory.
// One transaction at a time: grant -> ACCESS (mem_en) -> WAIT (read latency) -> DONE (valid pulse).
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t        r_state;
    state_t        w_state_next;
    req_t          r_last_grant;
    req_t          w_winner;

    logic          w_if_elig;
    logic          w_dm_elig;
    logic          w_grant;
    logic          w_store_done;
    logic          w_load_cnt;
    logic          w_capture;

    logic [3:0]    r_cnt;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_if_valid;
    logic          r_dm_valid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    // NOTE: reset is sampled on the rising edge only; there is no asynchronous path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_store_done = 1'b0;
        w_load_cnt   = 1'b0;
        w_capture    = 1'b0;
        w_winner     = REQ_DM;

        // The requester completing this cycle is masked so a held req starts fresh next cycle.
        w_if_elig = bus.if_req & ~r_if_valid;
        w_dm_elig = bus.dm_req & ~r_dm_valid;

        if (w_if_elig && w_dm_elig) begin
            w_winner = (r_last_grant == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (w_if_elig) begin
            w_winner = REQ_IF;
        end

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_if_elig || w_dm_elig) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ACCESS;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_mem_we) begin
                    w_store_done = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_load_cnt   = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= REQ_IF;
            r_cnt        <= 4'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_mem_en <= w_grant;
            r_mem_we <= w_grant && (w_winner == REQ_DM) && bus.dm_we;

            if (w_grant) begin
                r_last_grant <= w_winner;
                r_mem_addr   <= (w_winner == REQ_DM) ? bus.dm_addr : bus.if_addr;
                if (w_winner == REQ_DM) begin
                    r_mem_wdata <= bus.dm_wdata;
                end
            end

            if (w_load_cnt) begin
                r_cnt <= LAT_CNT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // r_last_grant still names the owner of the transaction in flight.
            r_if_valid <= w_capture && (r_last_grant == REQ_IF);
            r_dm_valid <= w_store_done || (w_capture && (r_last_grant == REQ_DM));

            if (w_capture && (r_last_grant == REQ_IF)) begin
                r_if_rdata <= bus.mem_rdata;
            end
            if (w_capture && (r_last_grant == REQ_DM)) begin
                r_dm_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.stall     = (bus.if_req & ~r_if_valid) | (bus.dm_req & ~r_dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a fixed-latency memory model
// and a transaction-level reference (latency, data, fairness bound, stall).
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam int N_RND = 1500;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Memory macro model: word array indexed by addr[9:2], read data valid LAT cycles after mem_en.
    logic [31:0] mem_arr [256];
    int          mcyc = 0;
    int          due  = -100;
    logic [31:0] due_data;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(i << 20);
    endfunction

    always @(posedge clk) begin : memory_model
        int          d;
        logic [31:0] dd;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            due           <= -100;
            bus.mem_rdata <= 32'hBAD0_0000;
        end else begin
            d  = due;
            dd = due_data;
            if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
            if (bus.mem_en && !bus.mem_we) begin
                d  = mcyc + LAT;
                dd = mem_arr[bus.mem_addr[9:2]];
            end
            due           <= d;
            due_data      <= dd;
            bus.mem_rdata <= (d == mcyc + 1) ? dd : (32'hBAD0_0000 | 32'(mcyc & 16'hFFFF));
        end
        mcyc <= mcyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Random-phase per-requester transaction state (index 0 = fetch, 1 = data).
    bit          act     [2];
    bit          en_seen [2];
    bit          is_st   [2];
    int          rise    [2];
    int          en_cyc  [2];
    logic [31:0] a       [2];
    logic [31:0] wd;

    task automatic new_txn(input int r, input int start);
        act[r]     = 1'b1;
        rise[r]    = start;
        en_seen[r] = 1'b0;
        if (r == 0) begin
            a[0]        = 32'($urandom_range(0, 255)) << 2;
            is_st[0]    = 1'b0;
            bus.if_addr = a[0];
            bus.if_req  = 1'b1;
        end else begin
            a[1]         = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2);
            is_st[1]     = 1'($urandom_range(0, 1));
            wd           = $urandom;
            bus.dm_addr  = a[1];
            bus.dm_we    = is_st[1];
            bus.dm_wdata = wd;
            bus.dm_req   = 1'b1;
        end
    endtask

    task automatic drop(input int r);
        act[r] = 1'b0;
        if (r == 0) bus.if_req = 1'b0;
        else        bus.dm_req = 1'b0;
    endtask

    initial begin
        int t;
        int prev;
        int n;
        bit seen;

        // Reset with both requesters already asserting.
        rst_n        = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h4;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h100;
        bus.dm_wdata = 32'h0;
        tick();
        tick();
        chk("rst_mem_en",    32'(bus.mem_en),   32'h0);
        chk("rst_mem_we",    32'(bus.mem_we),   32'h0);
        chk("rst_mem_addr",  bus.mem_addr,      32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,     32'h0);
        chk("rst_if_valid",  32'(bus.if_valid), 32'h0);
        chk("rst_dm_valid",  32'(bus.dm_valid), 32'h0);
        chk("rst_if_rdata",  bus.if_rdata,      32'h0);
        chk("rst_dm_rdata",  bus.dm_rdata,      32'h0);
        chk("rst_stall",     32'(bus.stall),    32'h1);

        // Simultaneous requests after reset: data wins the first tie.
        rst_n = 1'b1;
        t = cyc;
        tick();
        chk("tie_first_en",   32'(bus.mem_en), 32'h1);
        chk("tie_first_addr", bus.mem_addr,    32'h100);
        chk("tie_first_we",   32'(bus.mem_we), 32'h0);
        tick();
        tick();
        chk("tie_dm_not_early", 32'(bus.dm_valid), 32'h0);
        tick();
        chk("tie_dm_valid_t4", 32'(bus.dm_valid), 32'h1);
        chk("tie_dm_rdata",    bus.dm_rdata,      mem_arr[8'h40]);
        chk("tie_stall_if",    32'(bus.stall),    32'h1);
        bus.dm_req = 1'b0;
        tick();
        chk("tie_if_en_t5",   32'(bus.mem_en), 32'h1);
        chk("tie_if_addr_t5", bus.mem_addr,    32'h4);
        tick();
        tick();
        tick();
        chk("tie_if_valid_t8", 32'(bus.if_valid), 32'h1);
        chk("tie_if_rdata",    bus.if_rdata,      mem_arr[1]);
        chk("tie_dm_quiet",    32'(bus.dm_valid), 32'h0);
        bus.if_req = 1'b0;
        tick();

        // Single fetch from 0x10.
        bus.if_addr = 32'h10;
        bus.if_req  = 1'b1;
        tick();
        chk("fetch_en",    32'(bus.mem_en), 32'h1);
        chk("fetch_we",    32'(bus.mem_we), 32'h0);
        chk("fetch_addr",  bus.mem_addr,    32'h10);
        chk("fetch_stall", 32'(bus.stall),  32'h1);
        tick();
        chk("fetch_en_once", 32'(bus.mem_en), 32'h0);
        tick();
        chk("fetch_not_early", 32'(bus.if_valid), 32'h0);
        tick();
        chk("fetch_valid",       32'(bus.if_valid), 32'h1);
        chk("fetch_rdata",       bus.if_rdata,      32'hDEAD_BEEF);
        chk("fetch_stall_clear", 32'(bus.stall),    32'h0);
        bus.if_req = 1'b0;
        tick();
        chk("fetch_valid_drop", 32'(bus.if_valid), 32'h0);
        chk("fetch_rdata_hold", bus.if_rdata,      32'hDEAD_BEEF);

        // Store of 0x55 to 0x20.
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h20;
        bus.dm_wdata = 32'h55;
        bus.dm_req   = 1'b1;
        tick();
        chk("store_en",    32'(bus.mem_en), 32'h1);
        chk("store_we",    32'(bus.mem_we), 32'h1);
        chk("store_addr",  bus.mem_addr,    32'h20);
        chk("store_wdata", bus.mem_wdata,   32'h55);
        tick();
        chk("store_dm_valid",  32'(bus.dm_valid), 32'h1);
        chk("store_en_drop",   32'(bus.mem_en),   32'h0);
        chk("store_we_drop",   32'(bus.mem_we),   32'h0);
        chk("store_no_ifv",    32'(bus.if_valid), 32'h0);
        chk("store_addr_hold", bus.mem_addr,      32'h20);
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        tick();
        chk("store_valid_drop", 32'(bus.dm_valid), 32'h0);

        // Continuous contention after a fresh reset: strict alternation, one transaction apart.
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        bus.if_addr  = 32'h40;
        bus.dm_addr  = 32'h200;
        bus.dm_we    = 1'b0;
        bus.if_req   = 1'b1;
        bus.dm_req   = 1'b1;
        prev = cyc;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus.mem_en && n < 20);
            chk($sformatf("alt_en%0d", k),   32'(bus.mem_en), 32'h1);
            chk($sformatf("alt_addr%0d", k), bus.mem_addr, (k % 2 == 0) ? 32'h200 : 32'h40);
            chk($sformatf("alt_gap%0d", k),  32'(cyc - prev), (k == 0) ? 32'd1 : 32'(LAT + 2));
            chk($sformatf("alt_stall%0d", k), 32'(bus.stall), 32'h1);
            prev = cyc;
        end
        bus.dm_req = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.if_valid && n < 20);
        chk("alt_last_if_valid", 32'(bus.if_valid), 32'h1);
        chk("alt_last_latency",  32'(cyc - prev),   32'(LAT + 1));
        bus.if_req = 1'b0;
        tick();

        // Reset while a fetch waits for memory: the fetch is abandoned.
        bus.if_addr = 32'h80;
        bus.if_req  = 1'b1;
        tick();
        chk("rw_en", 32'(bus.mem_en), 32'h1);
        tick();
        rst_n      = 1'b0;
        bus.if_req = 1'b0;
        tick();
        chk("rw_rst_en",     32'(bus.mem_en),   32'h0);
        chk("rw_rst_ifv",    32'(bus.if_valid), 32'h0);
        chk("rw_rst_rdata",  bus.if_rdata,      32'h0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.if_valid || bus.mem_en) seen = 1'b1;
        end
        chk("rw_no_valid_after", 32'(seen), 32'h0);
        bus.if_addr = 32'h84;
        bus.if_req  = 1'b1;
        t = cyc;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.if_valid && n < 20);
        chk("rw_new_latency", 32'(cyc - t), 32'(LAT + 2));
        chk("rw_new_rdata",   bus.if_rdata, mem_arr[33]);
        bus.if_req = 1'b0;
        tick();

        // Randomized traffic against the transaction-level reference.
        for (int r = 0; r < 2; r++) begin
            act[r]     = 1'b0;
            en_seen[r] = 1'b0;
            is_st[r]   = 1'b0;
        end
        for (int i = 0; i < N_RND; i++) begin
            bit done_now [2];
            int r;
            tick();
            if (bus.mem_en) begin
                r = int'(bus.mem_addr[28]);
                chk("rnd_en_owner", 32'({act[r], en_seen[r]}), 32'h2);
                chk("rnd_en_addr",  bus.mem_addr,    a[r]);
                chk("rnd_en_we",    32'(bus.mem_we), 32'(is_st[r]));
                if (is_st[r]) chk("rnd_en_wdata", bus.mem_wdata, wd);
                chk("rnd_en_window", 32'((cyc > rise[r]) && (cyc <= rise[r] + LAT + 3)), 32'h1);
                en_seen[r] = 1'b1;
                en_cyc[r]  = cyc;
            end else begin
                chk("rnd_we_idle", 32'(bus.mem_we), 32'h0);
            end
            for (int q = 0; q < 2; q++)
                done_now[q] = act[q] && en_seen[q] && (cyc == en_cyc[q] + (is_st[q] ? 1 : LAT + 1));
            chk("rnd_stall", 32'(bus.stall),
                32'((act[0] && !done_now[0]) || (act[1] && !done_now[1])));
            chk("rnd_if_valid", 32'(bus.if_valid), 32'(done_now[0]));
            chk("rnd_dm_valid", 32'(bus.dm_valid), 32'(done_now[1]));
            if (done_now[0]) chk("rnd_if_rdata", bus.if_rdata, mem_arr[a[0][9:2]]);
            if (done_now[1] && !is_st[1]) chk("rnd_dm_rdata", bus.dm_rdata, mem_arr[a[1][9:2]]);
            for (int q = 0; q < 2; q++) begin
                if (act[q] && !en_seen[q] && cyc > rise[q] + LAT + 3) begin
                    chk("rnd_grant_wait", 32'(cyc - rise[q]), 32'(LAT + 3));
                    drop(q);
                end else if (done_now[q]) begin
                    if (i < N_RND - 40 && $urandom_range(0, 1) == 1) new_txn(q, cyc + 1);
                    else drop(q);
                end else if (!act[q] && i < N_RND - 40 && $urandom_range(0, 2) == 0) begin
                    new_txn(q, cyc);
                end
            end
        end
        chk("rnd_drained", 32'({act[0], act[1]}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
